// File: rtl/fft_stage_sequencer_if.sv
// Control and address bus between the FFT stage controller, the sample RAM and the
// butterfly datapath on one side and the stage sequencer on the other.
interface fft_stage_sequencer_if #(
  parameter int N_LOG2  = 10,
  parameter int TW_BITS = 5
);
  logic                start;
  logic [3:0]          stage;
  logic                stall;
  logic                rd_valid;
  logic [N_LOG2-1:0]   rd_addr_a;
  logic [N_LOG2-1:0]   rd_addr_b;
  logic [TW_BITS-1:0]  tw_idx;
  logic                bf_en;
  logic                bf_clr;
  logic                wr_valid;
  logic [N_LOG2-1:0]   wr_addr_a;
  logic [N_LOG2-1:0]   wr_addr_b;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, stage, stall,
    input  rd_valid, rd_addr_a, rd_addr_b, tw_idx, bf_en, bf_clr,
    input  wr_valid, wr_addr_a, wr_addr_b, busy, done, err
  );

  modport slave (
    input  start, stage, stall,
    output rd_valid, rd_addr_a, rd_addr_b, tw_idx, bf_en, bf_clr,
    output wr_valid, wr_addr_a, wr_addr_b, busy, done, err
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Address/strobe sequencer for one radix-2 DIT stage of the in-place FFT: issues the
// butterfly read pairs and twiddle indices, then replays the addresses for write-back.
module fft_stage_sequencer #(
  parameter int N_LOG2  = 10,
  parameter int TW_BITS = 5,
  parameter int RD_LAT  = 1,
  parameter int BF_LAT  = 4
) (
  input  logic                 clock_c,
  input  logic                 reset_n,
  fft_stage_sequencer_if.slave bus
);
  localparam int K_W    = N_LOG2 - 1;
  localparam int WR_LAT = RD_LAT + BF_LAT;
  localparam int D_W    = $clog2(WR_LAT + 1);
  localparam logic [K_W-1:0] K_ZERO     = K_W'(1'b0);
  localparam logic [K_W-1:0] K_ONE      = K_W'(1'b1);
  localparam logic [K_W-1:0] K_LAST     = {K_W{1'b1}};
  localparam logic [D_W-1:0] D_ONE      = D_W'(1'b1);
  localparam logic [D_W-1:0] DRAIN_LAST = D_W'(WR_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [N_LOG2-1:0] mask_f(input logic [3:0] s);
    mask_f = (N_LOG2'(1'b1) << s) - N_LOG2'(1'b1);
  endfunction

  // Lower address of the pair: k with a zero bit inserted at position s.
  function automatic logic [N_LOG2-1:0] addr_a_f(input logic [K_W-1:0] k, input logic [3:0] s);
    logic [N_LOG2-1:0] kk;
    logic [N_LOG2-1:0] m;
    kk = N_LOG2'(k);
    m  = mask_f(s);
    addr_a_f = ((kk & ~m) << 1'b1) | (kk & m);
  endfunction

  function automatic logic [N_LOG2-1:0] addr_b_f(input logic [K_W-1:0] k, input logic [3:0] s);
    addr_b_f = addr_a_f(k, s) | (N_LOG2'(1'b1) << s);
  endfunction

  // The ROM index is the top TW_BITS of the K_W-bit exponent.
  function automatic logic [TW_BITS-1:0] tw_f(input logic [K_W-1:0] k, input logic [3:0] s);
    logic [N_LOG2-1:0] m;
    logic [K_W-1:0]    e;
    m = mask_f(s);
    e = (k & m[K_W-1:0]) << (4'(K_W) - s);
    tw_f = e[K_W-1 -: TW_BITS];
  endfunction

  state_t              state_r;
  state_t              state_nxt;
  logic [3:0]          s_r;
  logic [K_W-1:0]      k_r;
  logic [D_W-1:0]      drain_r;
  logic [N_LOG2-1:0]   a_r;
  logic [N_LOG2-1:0]   b_r;
  logic [TW_BITS-1:0]  tw_r;
  logic                err_r;
  logic [WR_LAT-1:0]   vld_dly_r;
  logic [N_LOG2-1:0]   a_dly_r [WR_LAT];
  logic [N_LOG2-1:0]   b_dly_r [WR_LAT];
  logic [TW_BITS-1:0]  tw_dly_r [RD_LAT];
  logic                rd_valid_s;
  logic                bf_en_s;
  logic                stage_ok_s;

  assign stage_ok_s = (bus.stage < 4'(N_LOG2));

  // State register.
  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic and the stall-gated strobes.
  always_comb begin
    state_nxt  = state_r;
    rd_valid_s = 1'b0;
    bf_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && stage_ok_s) state_nxt = CLEAR;
        else                         state_nxt = IDLE;
      end
      CLEAR: state_nxt = ISSUE;
      ISSUE: begin
        if (!bus.stall) begin
          rd_valid_s = 1'b1;
          bf_en_s    = 1'b1;
          if (k_r == K_LAST) state_nxt = DRAIN;
          else               state_nxt = ISSUE;
        end else begin
          state_nxt = ISSUE;
        end
      end
      DRAIN: begin
        if (!bus.stall) begin
          bf_en_s = 1'b1;
          if (drain_r == DRAIN_LAST) state_nxt = DONE;
          else                       state_nxt = DRAIN;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage capture, butterfly counter and the registered read address/twiddle of the current pair.
  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      s_r     <= 4'd0;
      k_r     <= K_ZERO;
      drain_r <= {D_W{1'b0}};
      a_r     <= {N_LOG2{1'b0}};
      b_r     <= {N_LOG2{1'b0}};
      tw_r    <= {TW_BITS{1'b0}};
      err_r   <= 1'b0;
    end else begin
      err_r <= (state_r == IDLE) && bus.start && !stage_ok_s;
      if ((state_r == IDLE) && bus.start && stage_ok_s) s_r <= bus.stage;
      if (state_r == CLEAR) begin
        k_r     <= K_ZERO;
        drain_r <= {D_W{1'b0}};
        a_r     <= addr_a_f(K_ZERO, s_r);
        b_r     <= addr_b_f(K_ZERO, s_r);
        tw_r    <= tw_f(K_ZERO, s_r);
      end else if (rd_valid_s && (k_r != K_LAST)) begin
        k_r  <= k_r + K_ONE;
        a_r  <= addr_a_f(k_r + K_ONE, s_r);
        b_r  <= addr_b_f(k_r + K_ONE, s_r);
        tw_r <= tw_f(k_r + K_ONE, s_r);
      end
      if ((state_r == DRAIN) && bf_en_s) drain_r <= drain_r + D_ONE;
    end
  end

  // Write-back and twiddle delay lines; they move only with the butterfly pipeline.
  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      vld_dly_r <= {WR_LAT{1'b0}};
      for (int i = 0; i < WR_LAT; i++) begin
        a_dly_r[i] <= {N_LOG2{1'b0}};
        b_dly_r[i] <= {N_LOG2{1'b0}};
      end
      for (int i = 0; i < RD_LAT; i++) tw_dly_r[i] <= {TW_BITS{1'b0}};
    end else if (bf_en_s) begin
      vld_dly_r  <= {vld_dly_r[WR_LAT-2:0], rd_valid_s};
      a_dly_r[0] <= a_r;
      b_dly_r[0] <= b_r;
      for (int i = 1; i < WR_LAT; i++) begin
        a_dly_r[i] <= a_dly_r[i-1];
        b_dly_r[i] <= b_dly_r[i-1];
      end
      tw_dly_r[0] <= tw_r;
      for (int i = 1; i < RD_LAT; i++) tw_dly_r[i] <= tw_dly_r[i-1];
    end
  end

  assign bus.rd_valid  = rd_valid_s;
  assign bus.rd_addr_a = a_r;
  assign bus.rd_addr_b = b_r;
  assign bus.tw_idx    = tw_dly_r[RD_LAT-1];
  assign bus.bf_en     = bf_en_s;
  assign bus.bf_clr    = (state_r == CLEAR);
  assign bus.wr_valid  = vld_dly_r[WR_LAT-1] && bf_en_s;
  assign bus.wr_addr_a = a_dly_r[WR_LAT-1];
  assign bus.wr_addr_b = b_dly_r[WR_LAT-1];
  assign bus.busy      = (state_r != IDLE);
  assign bus.done      = (state_r == DONE);
  assign bus.err       = err_r;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized-stall bench for fft_stage_sequencer against a progress-count timeline model.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fft_stage_sequencer_if #(.N_LOG2(10), .TW_BITS(5)) bus ();

  fft_stage_sequencer #(.N_LOG2(10), .TW_BITS(5), .RD_LAT(1), .BF_LAT(4)) dut (
    .clock_c (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the butterfly numbering.
  function automatic int m_a(input int s, input int k);
    return (k / (2 ** s)) * (2 ** (s + 1)) + (k % (2 ** s));
  endfunction
  function automatic int m_b(input int s, input int k);
    return m_a(s, k) + 2 ** s;
  endfunction
  function automatic int m_tw(input int s, input int k);
    return ((k % (2 ** s)) * (2 ** (9 - s))) / 16;
  endfunction

  // Hand-computed anchor points: stage, k, a, b, tw (-1: not pinned).
  int pin_s  [7] = '{0, 0, 0,    3,  9,  9,   9};
  int pin_k  [7] = '{0, 1, 511,  13, 0,  17,  511};
  int pin_a  [7] = '{0, 2, 1022, 21, 0,  17,  511};
  int pin_b  [7] = '{1, 3, 1023, 29, 512, 529, 1023};
  int pin_tw [7] = '{0, -1, -1,  20, 0,  1,   31};

  // Model state: mode 0 idle / 1 stage; c = cycle in stage; n = non-stalled cycles after CLEAR.
  int mode = 0, c = 0, n = 0, sm = 0, wr_seen = 0, tw_exp = 0, pin_tw_exp = -1;
  bit tw_pend = 1'b0, err_exp = 1'b0, st;
  bit e_rdv, e_bfen, e_clr, e_wrv, e_done, e_busy;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_busy", bus.busy, 0);       chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_bf_en", bus.bf_en, 0);     chk("rst_bf_clr", bus.bf_clr, 0);
      chk("rst_wr_valid", bus.wr_valid, 0); chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);         chk("rst_tw_idx", bus.tw_idx, 0);
      chk("rst_rd_addr_a", bus.rd_addr_a, 0); chk("rst_rd_addr_b", bus.rd_addr_b, 0);
      chk("rst_wr_addr_a", bus.wr_addr_a, 0); chk("rst_wr_addr_b", bus.wr_addr_b, 0);
      mode = 0; tw_pend = 1'b0; pin_tw_exp = -1; err_exp = 1'b0;
    end else begin
      st = bus.stall;
      if (tw_pend) chk("tw_idx", bus.tw_idx, tw_exp);
      if (pin_tw_exp >= 0) chk("pin_tw_idx", bus.tw_idx, pin_tw_exp);
      tw_pend = 1'b0; pin_tw_exp = -1;
      e_rdv = 1'b0; e_bfen = 1'b0; e_clr = 1'b0; e_wrv = 1'b0; e_done = 1'b0;
      e_busy = (mode != 0);
      if (mode != 0) begin
        if (c == 1) e_clr = 1'b1;
        else if (n == 517) e_done = 1'b1;
        else begin
          e_bfen = !st;
          e_rdv  = !st && (n < 512);
          e_wrv  = !st && (n >= 5);
        end
      end
      chk("busy", bus.busy, e_busy);       chk("rd_valid", bus.rd_valid, e_rdv);
      chk("bf_en", bus.bf_en, e_bfen);     chk("bf_clr", bus.bf_clr, e_clr);
      chk("wr_valid", bus.wr_valid, e_wrv); chk("done", bus.done, e_done);
      chk("err", bus.err, err_exp);
      if (e_rdv) begin
        chk("rd_addr_a", bus.rd_addr_a, m_a(sm, n));
        chk("rd_addr_b", bus.rd_addr_b, m_b(sm, n));
        tw_pend = 1'b1; tw_exp = m_tw(sm, n);
        for (int i = 0; i < 7; i++) begin
          if (sm == pin_s[i] && n == pin_k[i]) begin
            chk("pin_rd_addr_a", bus.rd_addr_a, pin_a[i]);
            chk("pin_rd_addr_b", bus.rd_addr_b, pin_b[i]);
            pin_tw_exp = pin_tw[i];
          end
        end
      end
      if (e_wrv) begin
        chk("wr_addr_a", bus.wr_addr_a, m_a(sm, n - 5));
        chk("wr_addr_b", bus.wr_addr_b, m_b(sm, n - 5));
      end
      if (bus.wr_valid) wr_seen++;
      if (e_done) chk("wr_count", wr_seen, 512);
      // Advance the model across the coming edge.
      err_exp = 1'b0;
      if (mode == 0) begin
        if (bus.start) begin
          if (bus.stage < 4'd10) begin
            mode = 1; c = 1; n = 0; sm = int'(bus.stage); wr_seen = 0;
          end else begin
            err_exp = 1'b1;
          end
        end
      end else begin
        if (c == 1) begin
        end else if (n == 517) mode = 0;
        else if (!st) n++;
        c++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a stage and walk it with random stalls; reports the done cycle and counted stalls.
  task automatic run_stage(input int s, input int pct, input int ignore_at,
                           output int done_cy, output int stalls);
    bus.start = 1'b1;
    bus.stage = 4'(s);
    bus.stall = (pct > 0);
    done_cy = 0;
    stalls  = 0;
    for (int cy = 1; cy <= 3000; cy++) begin
      tick();
      bus.start = (cy == ignore_at);
      bus.stage = (cy == ignore_at) ? 4'd4 : 4'(s);
      bus.stall = ($urandom_range(99) < pct);
      #1;
      if (bus.done) begin
        done_cy = cy;
        break;
      end
      if (cy >= 2 && bus.stall) stalls++;
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic run_and_check(input int s, input int pct, input int ignore_at);
    int done_cy, stalls;
    run_stage(s, pct, ignore_at, done_cy, stalls);
    chk("done_cycle", done_cy, 519 + stalls);
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stage = 4'd0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    run_and_check(0, 0, 0);
    run_and_check(3, 0, 0);
    run_and_check(9, 0, 0);
    run_and_check(5, 30, 0);

    // Out-of-range stage request.
    bus.start = 1'b1;
    bus.stage = 4'd12;
    tick();
    bus.start = 1'b0;
    bus.stage = 4'd0;
    chk("err_pulse", bus.err, 1);
    chk("err_busy", bus.busy, 0);
    tick();
    chk("err_once", bus.err, 0);
    tick();

    // A second start during ISSUE must be ignored.
    run_and_check(1, 0, 100);

    // Abandon a stage with reset, then run a clean one.
    bus.start = 1'b1;
    bus.stage = 4'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 299; i++) begin
      tick();
      bus.stall = ($urandom_range(99) < 30);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_valid", bus.rd_valid, 0);
    chk("abort_wr_valid", bus.wr_valid, 0);
    chk("abort_rd_addr_b", bus.rd_addr_b, 0);
    bus.stall = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_and_check(2, 0, 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
